// File: rtl/button_conditioner.sv
// ============================================================================
// button_conditioner
//
// Purpose:
//   Cleans up the raw push-buttons (bit 0 pause, bit 1 speedup, bit 2
//   speeddown) before they reach the address/speed control stage. Each
//   channel is synchronised through two flops and then debounced by a
//   four-state FSM with a stability counter. The block provides a clean
//   level plus one-cycle press and release pulses for consumers that want
//   edges without doing their own detection.
//
// Ports:
//   clk          in   1      system clock, all flops on posedge
//   rst_n        in   1      asynchronous active-low reset
//   btn_raw      in   N_BTN  raw buttons, high when pressed, async to clk
//   btn_level    out  N_BTN  debounced level, high while accepted as pressed
//   btn_press    out  N_BTN  one-cycle pulse on accepted press
//                            (and on auto-repeat when HOLD_REPEAT_EN is set)
//   btn_release  out  N_BTN  one-cycle pulse on accepted release
//
// Optional feature (macro HOLD_REPEAT_EN):
//   When defined, a held button re-pulses btn_press REPEAT_DELAY cycles
//   after the initial press pulse and then every REPEAT_PERIOD cycles for
//   as long as the channel stays in PRESSED. btn_level is unaffected.
//   When undefined there is exactly one btn_press pulse per accepted press.
// ============================================================================
module button_conditioner #(
    parameter int N_BTN           = 3,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 20,
    parameter int REPEAT_DELAY    = 50000,
    parameter int REPEAT_PERIOD   = 12500
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    // Last count value of a WAIT state: reaching it with a still-stable
    // input means DEBOUNCE_CYCLES consecutive stable samples were seen.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Elaboration-time sanity checks on the configuration.
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("button_conditioner: DEBOUNCE_CYCLES must be >= 2");
    end
    if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
        $error("button_conditioner: CNT_W too narrow for DEBOUNCE_CYCLES");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("button_conditioner: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    // Synchroniser stages
    logic [N_BTN-1:0] sync1_q, sync1_d;
    logic [N_BTN-1:0] sync2_q, sync2_d;

    // Per-channel debounce state
    state_t           state_q [N_BTN];
    state_t           state_d [N_BTN];
    logic [CNT_W-1:0] cnt_q   [N_BTN];
    logic [CNT_W-1:0] cnt_d   [N_BTN];

    // Registered outputs
    logic [N_BTN-1:0] level_q,   level_d;
    logic [N_BTN-1:0] press_q,   press_d;
    logic [N_BTN-1:0] release_q, release_d;

`ifdef HOLD_REPEAT_EN
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam logic [HOLD_W-1:0] HOLD_FIRST = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] HOLD_NEXT  = HOLD_W'(REPEAT_PERIOD - 1);

    // hold counts cycles spent in PRESSED since the last press pulse;
    // repeating selects between the initial delay and the repeat period.
    logic [HOLD_W-1:0] hold_q [N_BTN];
    logic [HOLD_W-1:0] hold_d [N_BTN];
    logic [N_BTN-1:0]  repeating_q, repeating_d;
`endif

    // The FSM only ever looks at the second synchroniser stage, so raw
    // metastability never reaches the state decode.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
    end

    // Next-state logic for every channel. Channels never interact; the
    // pulse outputs default low so each pulse lasts exactly one cycle.
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            state_d[i]   = state_q[i];
            cnt_d[i]     = cnt_q[i];
            level_d[i]   = level_q[i];
            press_d[i]   = 1'b0;
            release_d[i] = 1'b0;
`ifdef HOLD_REPEAT_EN
            hold_d[i]      = hold_q[i];
            repeating_d[i] = repeating_q[i];
`endif

            case (state_q[i])
                ST_RELEASED: begin
                    if (sync2_q[i]) begin
                        state_d[i] = ST_PRESS_WAIT;
                        cnt_d[i]   = '0;
                    end
                end

                ST_PRESS_WAIT: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = ST_RELEASED;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = ST_PRESSED;
                        level_d[i] = 1'b1;
                        press_d[i] = 1'b1;
`ifdef HOLD_REPEAT_EN
                        hold_d[i]      = '0;
                        repeating_d[i] = 1'b0;
`endif
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end

                ST_PRESSED: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = ST_RELEASE_WAIT;
                        cnt_d[i]   = '0;
                    end
`ifdef HOLD_REPEAT_EN
                    // Hold time accrues only while the button stays
                    // pressed; a bounce through RELEASE_WAIT freezes it.
                    else if (hold_q[i] == (repeating_q[i] ? HOLD_NEXT : HOLD_FIRST)) begin
                        press_d[i]     = 1'b1;
                        hold_d[i]      = '0;
                        repeating_d[i] = 1'b1;
                    end else begin
                        hold_d[i] = hold_q[i] + HOLD_W'(1);
                    end
`endif
                end

                ST_RELEASE_WAIT: begin
                    if (sync2_q[i]) begin
                        state_d[i] = ST_PRESSED;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i]   = ST_RELEASED;
                        level_d[i]   = 1'b0;
                        release_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end

                default: begin
                    state_d[i] = ST_RELEASED;
                    cnt_d[i]   = '0;
                    level_d[i] = 1'b0;
                end
            endcase
        end
    end

    // All state and outputs; reset clears everything without emitting a
    // release pulse, so a held button is re-debounced from scratch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= ST_RELEASED;
                cnt_q[i]   <= '0;
            end
`ifdef HOLD_REPEAT_EN
            repeating_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                hold_q[i] <= '0;
            end
`endif
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
`ifdef HOLD_REPEAT_EN
            repeating_q <= repeating_d;
            for (int i = 0; i < N_BTN; i++) begin
                hold_q[i] <= hold_d[i];
            end
`endif
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule

// File: tb/tb_button_conditioner.sv
// ============================================================================
// tb_button_conditioner
//
// Purpose:
//   Directed self-checking bench for button_conditioner with
//   DEBOUNCE_CYCLES=4, REPEAT_DELAY=10 and REPEAT_PERIOD=5. Inputs change
//   just after a falling edge so the next rising edge is "edge 1"; outputs
//   are sampled on falling edges, half a cycle after the active edge.
//   Honours HOLD_REPEAT_EN to select the long-hold expectations.
// ============================================================================
module tb_button_conditioner;

    localparam int N_BTN = 3;

    logic             clk;
    logic             rst_n;
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;

    int n_checks;
    int n_fail;

    button_conditioner #(
        .N_BTN          (N_BTN),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    // 10 time-unit clock period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance n cycles, ending on a falling edge
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Clean reset with buttons released; returns on the falling edge just
    // before edge 1 of the next test.
    task automatic do_reset();
        @(negedge clk);
        btn_raw = '0;
        rst_n   = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    // All three buttons held through reset: outputs stay 0, then all
    // three channels accept together after edge 7.
    task automatic test_reset();
        rst_n   = 1'b0;
        btn_raw = 3'b111;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            n_checks++;
            if ({btn_level, btn_press, btn_release} !== 9'b0) begin
                n_fail++;
                $display("[TB] FAIL reset_hold: outputs=%b required=%b", {btn_level, btn_press, btn_release}, 9'b0);
            end
        end
        rst_n = 1'b1;
        tick(6);
        n_checks++;
        if (btn_level !== 3'b000 || btn_press !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL reset_early_e6: level=%b press=%b required 000/000", btn_level, btn_press);
        end
        tick(1);
        n_checks++;
        if (btn_level !== 3'b111 || btn_press !== 3'b111 || btn_release !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL reset_accept_e7: level=%b press=%b release=%b required 111/111/000", btn_level, btn_press, btn_release);
        end
        tick(1);
        n_checks++;
        if (btn_level !== 3'b111 || btn_press !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL reset_pulse_end_e8: level=%b press=%b required 111/000", btn_level, btn_press);
        end
    endtask

    // Press bit 0 before edge 1, release before edge 20
    task automatic test_clean_press_release();
        do_reset();
        btn_raw = 3'b001;
        tick(6);
        n_checks++;
        if (btn_level !== 3'b000 || btn_press !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL clean_press_early_e6: level=%b press=%b required 000/000", btn_level, btn_press);
        end
        tick(1);
        n_checks++;
        if (btn_level !== 3'b001 || btn_press !== 3'b001 || btn_release !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL clean_press_e7: level=%b press=%b release=%b required 001/001/000", btn_level, btn_press, btn_release);
        end
        tick(1);
        n_checks++;
        if (btn_level !== 3'b001 || btn_press !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL clean_press_e8: level=%b press=%b required 001/000", btn_level, btn_press);
        end
        tick(11);
        btn_raw = 3'b000;
        tick(6);
        n_checks++;
        if (btn_level !== 3'b001 || btn_release !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL clean_release_early_e25: level=%b release=%b required 001/000", btn_level, btn_release);
        end
        tick(1);
        n_checks++;
        if (btn_level !== 3'b000 || btn_release !== 3'b001 || btn_press !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL clean_release_e26: level=%b release=%b press=%b required 000/001/000", btn_level, btn_release, btn_press);
        end
        tick(1);
        n_checks++;
        if (btn_release !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL clean_release_e27: release=%b required 000", btn_release);
        end
    endtask

    // Two-cycle high glitch on bit 1 must be ignored entirely
    task automatic test_glitch();
        do_reset();
        btn_raw = 3'b010;
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            if (k == 2) btn_raw = 3'b000;
            n_checks++;
            if ({btn_level, btn_press, btn_release} !== 9'b0) begin
                n_fail++;
                $display("[TB] FAIL glitch_e%0d: outputs=%b required=%b", k, {btn_level, btn_press, btn_release}, 9'b0);
            end
        end
    endtask

    // Two-cycle low bounce on bit 2 while pressed must be ignored
    task automatic test_release_bounce();
        do_reset();
        btn_raw = 3'b100;
        tick(8);
        n_checks++;
        if (btn_level !== 3'b100) begin
            n_fail++;
            $display("[TB] FAIL bounce_setup_e8: level=%b required 100", btn_level);
        end
        btn_raw = 3'b000;
        for (int k = 9; k <= 16; k++) begin
            tick(1);
            if (k == 10) btn_raw = 3'b100;
            n_checks++;
            if (btn_level !== 3'b100 || btn_press !== 3'b000 || btn_release !== 3'b000) begin
                n_fail++;
                $display("[TB] FAIL bounce_e%0d: level=%b press=%b release=%b required 100/000/000", k, btn_level, btn_press, btn_release);
            end
        end
    endtask

    // Reset mid-cycle while bit 0 is held: immediate drop, no release
    // pulse, then a fresh press pulse 7 edges after reset is released.
    task automatic test_mid_reset();
        do_reset();
        btn_raw = 3'b001;
        tick(8);
        n_checks++;
        if (btn_level !== 3'b001) begin
            n_fail++;
            $display("[TB] FAIL midreset_setup: level=%b required 001", btn_level);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({btn_level, btn_press, btn_release} !== 9'b0) begin
            n_fail++;
            $display("[TB] FAIL midreset_async: outputs=%b required=%b", {btn_level, btn_press, btn_release}, 9'b0);
        end
        for (int k = 0; k < 2; k++) begin
            tick(1);
            n_checks++;
            if ({btn_level, btn_press, btn_release} !== 9'b0) begin
                n_fail++;
                $display("[TB] FAIL midreset_hold: outputs=%b required=%b", {btn_level, btn_press, btn_release}, 9'b0);
            end
        end
        rst_n = 1'b1;
        tick(6);
        n_checks++;
        if (btn_level !== 3'b000 || btn_press !== 3'b000 || btn_release !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL midreset_early_e6: level=%b press=%b release=%b required 000/000/000", btn_level, btn_press, btn_release);
        end
        tick(1);
        n_checks++;
        if (btn_level !== 3'b001 || btn_press !== 3'b001) begin
            n_fail++;
            $display("[TB] FAIL midreset_repress_e7: level=%b press=%b required 001/001", btn_level, btn_press);
        end
    endtask

    // Long hold on bit 1, released before edge 28. With auto-repeat the
    // press pulses land on edges 7, 17, 22, 27; without it only edge 7.
    // The release pulse follows after edge 34 in both builds.
    task automatic test_hold();
        logic exp_press;
        do_reset();
        btn_raw = 3'b010;
        for (int k = 1; k <= 39; k++) begin
            tick(1);
            if (k == 27) btn_raw = 3'b000;
`ifdef HOLD_REPEAT_EN
            exp_press = (k == 7 || k == 17 || k == 22 || k == 27);
`else
            exp_press = (k == 7);
`endif
            n_checks++;
            if (btn_press !== {1'b0, exp_press, 1'b0}) begin
                n_fail++;
                $display("[TB] FAIL hold_press_e%0d: press=%b required %b", k, btn_press, {1'b0, exp_press, 1'b0});
            end
            n_checks++;
            if (btn_release !== {1'b0, (k == 34), 1'b0} || btn_level !== {1'b0, (k >= 7 && k < 34), 1'b0}) begin
                n_fail++;
                $display("[TB] FAIL hold_level_rel_e%0d: level=%b release=%b required %b/%b", k, btn_level, btn_release,
                         {1'b0, (k >= 7 && k < 34), 1'b0}, {1'b0, (k == 34), 1'b0});
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        btn_raw  = '0;
        $display("[TB] Starting button_conditioner bench");
        test_reset();
        test_clean_press_release();
        test_glitch();
        test_release_bounce();
        test_mid_reset();
        test_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
